// File: rtl/seg_scan_drv.sv
// Multiplexed seven-segment scan driver: shadows digit codes, dp and blank flags,
// then scans one digit per DIV-cycle dwell, starting each dwell with a dark cycle.
module seg_scan_drv #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned DIV            = 50000,
  parameter bit          HEX_EN         = 1'b1,
  parameter bit          LZ_EN          = 1'b0,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIG_W = 4 * DIGITS;
  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [DIG_W-1:0]  sh_dig;
  logic [DIGITS-1:0] sh_dp;
  logic [DIGITS-1:0] sh_blank;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              guard, guard_nxt;
  logic              frame_nxt;

  logic              zero_run;
  logic [3:0]        cur_nib;
  logic              cur_dp, cur_blank, cur_zero, suppress_c, dark_c;
  logic [DIGITS-1:0] onehot;
  logic [7:0]        raw_c, seg_c;
  logic [DIGITS-1:0] sel_c;
  logic              last_c, wrap_c;

  // Active-low g..a pattern for one code; dp handled separately
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = HEX_EN ? 7'h08 : 7'h7E;
      4'hB: g = HEX_EN ? 7'h03 : 7'h7E;
      4'hC: g = HEX_EN ? 7'h46 : 7'h7E;
      4'hD: g = HEX_EN ? 7'h21 : 7'h7E;
      4'hE: g = HEX_EN ? 7'h06 : 7'h7E;
      4'hF: g = HEX_EN ? 7'h0E : 7'h7E;
    endcase
    return g;
  endfunction

  // Select the current digit; zero_run tracks "this and all higher nibbles are zero"
  always_comb begin
    zero_run  = 1'b1;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_zero  = 1'b0;
    onehot    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (sh_dig[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == idx) begin
        cur_nib   = sh_dig[4*i +: 4];
        cur_dp    = sh_dp[i];
        cur_blank = sh_blank[i];
        cur_zero  = zero_run;
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    suppress_c = LZ_EN && (idx != '0) && cur_zero;
    raw_c      = {~cur_dp, suppress_c ? 7'h7F : glyph(cur_nib)};
    seg_c      = SEG_ACTIVE_LOW ? raw_c : ~raw_c;
    sel_c      = SEL_ACTIVE_LOW ? ~onehot : onehot;
    dark_c     = guard | cur_blank;
  end

  // Scan sequencing: cnt paces the dwell, guard marks the anti-ghost dark cycle
  always_comb begin
    last_c    = (cnt == CNT_W'(DIV - 1));
    wrap_c    = (idx == IDX_W'(DIGITS - 1));
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    guard_nxt = 1'b1;
    frame_nxt = 1'b0;
    if (en) begin
      if (last_c) begin
        cnt_nxt   = '0;
        idx_nxt   = wrap_c ? '0 : idx + IDX_W'(1);
        frame_nxt = wrap_c;
      end else begin
        cnt_nxt   = cnt + CNT_W'(1);
        guard_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_dig     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      cnt        <= '0;
      idx        <= '0;
      guard      <= 1'b1;
      seg        <= SEG_OFF;
      sel        <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        sh_dig   <= digits_in;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
      end
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      guard      <= guard_nxt;
      seg        <= dark_c ? SEG_OFF : seg_c;
      sel        <= dark_c ? SEL_OFF : sel_c;
      frame_done <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv: three parameter variants share one stimulus stream.
module tb_seg_scan_drv;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in;

  logic [7:0] seg_a, seg_b, seg_c;
  logic [3:0] sel_a, sel_b, sel_c;
  logic       fd_a, fd_b, fd_c;

  int total = 0;
  int bad   = 0;

  logic [3:0] sel_lo [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [3:0] sel_hi [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

  always #5 clk = ~clk;

  // a: hex, no LZ, active-low; b: no hex, LZ, active-low; c: hex, no LZ, active-high
  seg_scan_drv #(.DIGITS(4), .DIV(4), .HEX_EN(1'b1), .LZ_EN(1'b0),
                 .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .seg(seg_a), .sel(sel_a), .frame_done(fd_a));
  seg_scan_drv #(.DIGITS(4), .DIV(4), .HEX_EN(1'b0), .LZ_EN(1'b1),
                 .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .seg(seg_b), .sel(sel_b), .frame_done(fd_b));
  seg_scan_drv #(.DIGITS(4), .DIV(4), .HEX_EN(1'b1), .LZ_EN(1'b0),
                 .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .seg(seg_c), .sel(sel_c), .frame_done(fd_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then arm en+load so the next edge (E1) captures the data
  task automatic start(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] blk);
    rst = 1'b1; en = 1'b0; load = 1'b0;
    tick(); tick();
    rst = 1'b0; en = 1'b1; load = 1'b1;
    digits_in = dig; dp_in = dp; blank_in = blk;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1;
    digits_in = 16'h8888; dp_in = 4'hF; blank_in = 4'h0;
    tick(); tick();
    total++; if (seg_a !== 8'hFF) begin bad++; $display("FAIL reset_seg_a got=%h exp=ff", seg_a); end
    total++; if (sel_a !== 4'hF)  begin bad++; $display("FAIL reset_sel_a got=%h exp=f", sel_a); end
    total++; if (fd_a !== 1'b0)   begin bad++; $display("FAIL reset_fd_a got=%b exp=0", fd_a); end
    total++; if (seg_c !== 8'h00) begin bad++; $display("FAIL reset_seg_c got=%h exp=00", seg_c); end
    total++; if (sel_c !== 4'h0)  begin bad++; $display("FAIL reset_sel_c got=%h exp=0", sel_c); end
  endtask

  task automatic test_scan();
    logic [7:0] g [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    int pos, d;
    bit lit, fd;
    start(16'h1234, 4'h0, 4'h0);
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e == 1) load = 1'b0;
      pos = (e - 1) % 16; d = pos / 4; lit = (pos % 4) != 0; fd = (e % 16) == 0;
      total++; if (seg_a !== (lit ? g[d] : 8'hFF)) begin bad++; $display("FAIL scan_seg_a e=%0d got=%h exp=%h", e, seg_a, lit ? g[d] : 8'hFF); end
      total++; if (sel_a !== (lit ? sel_lo[d] : 4'hF)) begin bad++; $display("FAIL scan_sel_a e=%0d got=%h exp=%h", e, sel_a, lit ? sel_lo[d] : 4'hF); end
      total++; if (seg_b !== (lit ? g[d] : 8'hFF)) begin bad++; $display("FAIL scan_seg_b e=%0d got=%h exp=%h", e, seg_b, lit ? g[d] : 8'hFF); end
      total++; if (seg_c !== (lit ? ~g[d] : 8'h00)) begin bad++; $display("FAIL scan_seg_c e=%0d got=%h exp=%h", e, seg_c, lit ? ~g[d] : 8'h00); end
      total++; if (sel_c !== (lit ? sel_hi[d] : 4'h0)) begin bad++; $display("FAIL scan_sel_c e=%0d got=%h exp=%h", e, sel_c, lit ? sel_hi[d] : 4'h0); end
      total++; if (fd_a !== fd) begin bad++; $display("FAIL scan_fd_a e=%0d got=%b exp=%b", e, fd_a, fd); end
      total++; if (fd_c !== fd) begin bad++; $display("FAIL scan_fd_c e=%0d got=%b exp=%b", e, fd_c, fd); end
    end
  endtask

  task automatic test_hex();
    logic [7:0] ga [4] = '{8'h8E, 8'hC6, 8'h83, 8'h88};
    logic [7:0] gc [4] = '{8'h71, 8'h39, 8'h7C, 8'h77};
    int d;
    start(16'hABCF, 4'h0, 4'h0);
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 1) load = 1'b0;
      d = (e - 1) / 4;
      if ((e - 1) % 4 == 1) begin
        total++; if (seg_a !== ga[d]) begin bad++; $display("FAIL hex_seg_a d=%0d got=%h exp=%h", d, seg_a, ga[d]); end
        total++; if (seg_b !== 8'hFE) begin bad++; $display("FAIL hex_err_seg_b d=%0d got=%h exp=fe", d, seg_b); end
        total++; if (seg_c !== gc[d]) begin bad++; $display("FAIL hex_seg_c d=%0d got=%h exp=%h", d, seg_c, gc[d]); end
      end
    end
  endtask

  task automatic test_lz();
    logic [7:0] ga [4] = '{8'hC0, 8'h92, 8'h40, 8'hC0};
    logic [7:0] gb [4] = '{8'hC0, 8'h92, 8'h7F, 8'hFF};
    logic [7:0] gc [4] = '{8'h3F, 8'h6D, 8'hBF, 8'h3F};
    int d;
    start(16'h0050, 4'b0100, 4'h0);
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 1) load = 1'b0;
      d = (e - 1) / 4;
      if ((e - 1) % 4 == 2) begin
        total++; if (seg_a !== ga[d]) begin bad++; $display("FAIL lz_off_seg_a d=%0d got=%h exp=%h", d, seg_a, ga[d]); end
        total++; if (seg_b !== gb[d]) begin bad++; $display("FAIL lz_on_seg_b d=%0d got=%h exp=%h", d, seg_b, gb[d]); end
        total++; if (sel_b !== sel_lo[d]) begin bad++; $display("FAIL lz_sel_b d=%0d got=%h exp=%h", d, sel_b, sel_lo[d]); end
        total++; if (seg_c !== gc[d]) begin bad++; $display("FAIL lz_seg_c d=%0d got=%h exp=%h", d, seg_c, gc[d]); end
      end
    end
  endtask

  task automatic test_blank();
    logic [7:0] ga [4] = '{8'h99, 8'hFF, 8'hA4, 8'hF9};
    logic [3:0] sa [4] = '{4'hE, 4'hF, 4'hB, 4'h7};
    logic [7:0] gc [4] = '{8'h66, 8'h00, 8'h5B, 8'h06};
    logic [3:0] sc [4] = '{4'h1, 4'h0, 4'h4, 4'h8};
    int d;
    start(16'h1234, 4'h0, 4'b0010);
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 1) load = 1'b0;
      d = (e - 1) / 4;
      if ((e - 1) % 4 == 3) begin
        total++; if (seg_a !== ga[d]) begin bad++; $display("FAIL blank_seg_a d=%0d got=%h exp=%h", d, seg_a, ga[d]); end
        total++; if (sel_a !== sa[d]) begin bad++; $display("FAIL blank_sel_a d=%0d got=%h exp=%h", d, sel_a, sa[d]); end
        total++; if (seg_c !== gc[d]) begin bad++; $display("FAIL blank_seg_c d=%0d got=%h exp=%h", d, seg_c, gc[d]); end
        total++; if (sel_c !== sc[d]) begin bad++; $display("FAIL blank_sel_c d=%0d got=%h exp=%h", d, sel_c, sc[d]); end
      end
    end
  endtask

  task automatic test_enable();
    logic [7:0] es [12] = '{8'hFF, 8'h99, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                            8'h99, 8'hFF, 8'hB0, 8'hB0};
    logic [3:0] ss [12] = '{4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                            4'hE, 4'hF, 4'hD, 4'hD};
    start(16'h1234, 4'h0, 4'h0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 1) load = 1'b0;
      if (e == 2) en = 1'b0;
      if (e == 7) en = 1'b1;
      total++; if (seg_a !== es[e-1]) begin bad++; $display("FAIL en_seg_a e=%0d got=%h exp=%h", e, seg_a, es[e-1]); end
      total++; if (sel_a !== ss[e-1]) begin bad++; $display("FAIL en_sel_a e=%0d got=%h exp=%h", e, sel_a, ss[e-1]); end
      total++; if (fd_a !== 1'b0) begin bad++; $display("FAIL en_fd_a e=%0d got=%b exp=0", e, fd_a); end
    end
  endtask

  task automatic test_load_wrap_rst();
    start(16'h1234, 4'h0, 4'h0);
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 1) load = 1'b0;
    end
    digits_in = 16'h5678; load = 1'b1;
    tick();  // E16: idx wraps while new data is captured
    load = 1'b0;
    total++; if (seg_a !== 8'hF9) begin bad++; $display("FAIL wrap_old_seg_a got=%h exp=f9", seg_a); end
    total++; if (fd_a !== 1'b1)   begin bad++; $display("FAIL wrap_fd_a got=%b exp=1", fd_a); end
    tick();  // E17
    total++; if (seg_a !== 8'hFF) begin bad++; $display("FAIL wrap_guard_seg_a got=%h exp=ff", seg_a); end
    total++; if (fd_a !== 1'b0)   begin bad++; $display("FAIL wrap_fd_clr_a got=%b exp=0", fd_a); end
    tick();  // E18
    total++; if (seg_a !== 8'h80) begin bad++; $display("FAIL wrap_new_seg_a got=%h exp=80", seg_a); end
    total++; if (sel_a !== 4'hE)  begin bad++; $display("FAIL wrap_new_sel_a got=%h exp=e", sel_a); end
    total++; if (seg_b !== 8'h80) begin bad++; $display("FAIL wrap_new_seg_b got=%h exp=80", seg_b); end
    total++; if (seg_c !== 8'h7F) begin bad++; $display("FAIL wrap_new_seg_c got=%h exp=7f", seg_c); end
    tick();  // E19
    rst = 1'b1; load = 1'b1; digits_in = 16'h9999; dp_in = 4'hF;
    tick();  // E20: reset wins over en and load
    total++; if (seg_a !== 8'hFF) begin bad++; $display("FAIL rst_seg_a got=%h exp=ff", seg_a); end
    total++; if (sel_a !== 4'hF)  begin bad++; $display("FAIL rst_sel_a got=%h exp=f", sel_a); end
    total++; if (fd_a !== 1'b0)   begin bad++; $display("FAIL rst_fd_a got=%b exp=0", fd_a); end
    total++; if (seg_c !== 8'h00) begin bad++; $display("FAIL rst_seg_c got=%h exp=00", seg_c); end
    rst = 1'b0; load = 1'b0;
    tick();  // E21
    total++; if (seg_a !== 8'hFF) begin bad++; $display("FAIL rst_guard_seg_a got=%h exp=ff", seg_a); end
    tick();  // E22: digit 0 with cleared shadow
    total++; if (seg_a !== 8'hC0) begin bad++; $display("FAIL rst_d0_seg_a got=%h exp=c0", seg_a); end
    total++; if (sel_a !== 4'hE)  begin bad++; $display("FAIL rst_d0_sel_a got=%h exp=e", sel_a); end
    total++; if (seg_b !== 8'hC0) begin bad++; $display("FAIL rst_d0_seg_b got=%h exp=c0", seg_b); end
    total++; if (seg_c !== 8'h3F) begin bad++; $display("FAIL rst_d0_seg_c got=%h exp=3f", seg_c); end
    total++; if (sel_c !== 4'h1)  begin bad++; $display("FAIL rst_d0_sel_c got=%h exp=1", sel_c); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0;
    digits_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
    test_reset();
    test_scan();
    test_hex();
    test_lz();
    test_blank();
    test_enable();
    test_load_wrap_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
